// File: rtl/easyaxi_ar_arb_pkg.sv
// Shared AXI widths and arbiter helpers for the AR-channel arbiter.
// Stands in for the easy_axi_define.v defaults so every file sees one value.
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_AR_NUM_MST
`define AXI_AR_NUM_MST 4
`endif

package easyaxi_ar_arb_pkg;

    localparam int DEF_NUM_MST = `AXI_AR_NUM_MST;

    // Round-robin successor of a master index, wrapping at n.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/easyaxi_rr_arb.sv
// Round-robin winner search with its own priority pointer.
// Ports: clk, rst, req (per-master), advance (handshake) -> grant (one-hot), idx.
module easyaxi_rr_arb
    import easyaxi_ar_arb_pkg::*;
#(
    parameter int N     = DEF_NUM_MST,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] rr_ptr;
    logic             found;
    int               j;

    // First requester at or above rr_ptr, wrapping to 0.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(rr_ptr) + k) % N;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
    end

    // Pointer moves only on a real handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (advance) begin
            rr_ptr <= IDX_W'(rr_next(int'(idx), N));
        end
    end

endmodule

// File: rtl/easyaxi_ar_arb.sv
// N-to-1 AXI AR-channel arbiter with one output register stage.
// Ports: clk, rst, enable, s_ar{valid,ready,id,addr} per master, m_ar{valid,ready,id,addr}, busy.
module easyaxi_ar_arb
    import easyaxi_ar_arb_pkg::*;
#(
    parameter  int NUM_MST = `AXI_AR_NUM_MST,
    parameter  int ID_W    = `AXI_ID_WIDTH,
    parameter  int ADDR_W  = `AXI_ADDR_WIDTH,
    localparam int IDX_W   = $clog2(NUM_MST)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [NUM_MST-1:0]        s_arvalid,
    output logic [NUM_MST-1:0]        s_arready,
    input  logic [NUM_MST*ID_W-1:0]   s_arid,
    input  logic [NUM_MST*ADDR_W-1:0] s_araddr,
    output logic                      m_arvalid,
    input  logic                      m_arready,
    output logic [IDX_W+ID_W-1:0]     m_arid,
    output logic [ADDR_W-1:0]         m_araddr,
    output logic                      busy
);

    logic                   out_valid;
    logic [IDX_W+ID_W-1:0]  out_id;
    logic [ADDR_W-1:0]      out_addr;

    logic [NUM_MST-1:0]     grant;
    logic [IDX_W-1:0]       win_idx;
    logic [ID_W-1:0]        sel_id;
    logic [ADDR_W-1:0]      sel_addr;
    logic                   load_ok;
    logic                   load;

    easyaxi_rr_arb #(
        .N     (NUM_MST),
        .IDX_W (IDX_W)
    ) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (s_arvalid),
        .advance (load),
        .grant   (grant),
        .idx     (win_idx)
    );

    // Grant is one-hot, so a plain priority mux is enough.
    always_comb begin
        sel_id   = '0;
        sel_addr = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            if (grant[i]) begin
                sel_id   = s_arid[i*ID_W +: ID_W];
                sel_addr = s_araddr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // rst gating keeps s_arready low during an asserted reset.
    assign load_ok   = enable & (~out_valid | m_arready) & ~rst;
    assign s_arready = grant & {NUM_MST{load_ok}};
    assign load      = |s_arready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_id    <= '0;
            out_addr  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_id    <= {win_idx, sel_id};
            out_addr  <= sel_addr;
        end else if (m_arready) begin
            out_valid <= 1'b0;
        end
    end

    assign m_arvalid = out_valid;
    assign m_arid    = out_id;
    assign m_araddr  = out_addr;
    assign busy      = out_valid;

endmodule

// File: tb/tb_easyaxi_ar_arb.sv
// Self-checking bench for easyaxi_ar_arb: directed scenarios plus random traffic.
// Checks every output each cycle against a behavioural model of the arbiter.
module tb_easyaxi_ar_arb;

    localparam int N  = 4;
    localparam int IW = 4;
    localparam int AW = 32;
    localparam int XW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic [N-1:0]      s_arvalid;
    logic [N-1:0]      s_arready;
    logic [N*IW-1:0]   s_arid;
    logic [N*AW-1:0]   s_araddr;
    logic              m_arvalid;
    logic              m_arready;
    logic [XW+IW-1:0]  m_arid;
    logic [AW-1:0]     m_araddr;
    logic              busy;

    easyaxi_ar_arb dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_arid    (s_arid),
        .s_araddr  (s_araddr),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_arid    (m_arid),
        .m_araddr  (m_araddr),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: the pending output slot and who is next in line.
    bit               mv;
    logic [XW+IW-1:0] mid;
    logic [AW-1:0]    maddr;
    int               ptr;

    logic [XW+IW-1:0] held_id;
    logic [AW-1:0]    held_addr;

    task automatic chk(input string tag, input logic [63:0] o,
                       input logic [63:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    function automatic int winner();
        for (int k = 0; k < N; k++) begin
            if (s_arvalid[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int w;
        w = winner();
        if (enable && (!mv || m_arready) && w >= 0) return N'(1) << w;
        return '0;
    endfunction

    task automatic check_all();
        chk("s_arready", 64'(s_arready), 64'(exp_ready()));
        chk("m_arvalid", 64'(m_arvalid), 64'(mv));
        chk("busy", 64'(busy), 64'(mv));
        if (mv) begin
            chk("m_arid", 64'(m_arid), 64'(mid));
            chk("m_araddr", 64'(m_araddr), 64'(maddr));
        end
    endtask

    task automatic model_step();
        int w;
        w = winner();
        if (enable && (!mv || m_arready) && w >= 0) begin
            mv    = 1'b1;
            mid   = {XW'(w), s_arid[w*IW +: IW]};
            maddr = s_araddr[w*AW +: AW];
            ptr   = (w + 1) % N;
        end else if (mv && m_arready) begin
            mv = 1'b0;
        end
    endtask

    task automatic cycle();
        #1;
        check_all();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_m_arvalid", 64'(m_arvalid), 64'd0);
        chk("rst_s_arready", 64'(s_arready), 64'd0);
        mv    = 1'b0;
        mid   = '0;
        maddr = '0;
        ptr   = 0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_m_arid", 64'(m_arid), 64'd0);
        chk("rst_m_araddr", 64'(m_araddr), 64'd0);
        rst = 1'b0;
    endtask

    task automatic rand_payload();
        for (int i = 0; i < N; i++) begin
            s_arid[i*IW +: IW]   = IW'($urandom);
            s_araddr[i*AW +: AW] = $urandom;
        end
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b1;
        s_arvalid = '0;
        s_arid    = '0;
        s_araddr  = '0;
        m_arready = 1'b0;
        mv = 1'b0; mid = '0; maddr = '0; ptr = 0;
        @(negedge clk);
        do_reset();

        // Single request from master 0.
        s_arvalid = 4'b0001;
        s_arid[0 +: IW] = 4'h3;
        s_araddr[0 +: AW] = 32'h100;
        m_arready = 1'b1;
        #1;
        chk("single_grant", 64'(s_arready), 64'h1);
        cycle();
        chk("single_valid", 64'(m_arvalid), 64'd1);
        chk("single_id", 64'(m_arid), 64'h03);
        chk("single_addr", 64'(m_araddr), 64'h100);
        s_arvalid = '0;
        cycle();

        // Fairness with every master holding valid.
        do_reset();
        s_arvalid = 4'b1111;
        m_arready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            rand_payload();
            cycle();
            chk("fair_order", 64'(m_arid[XW+IW-1:IW]), 64'(k % N));
            chk("fair_valid", 64'(m_arvalid), 64'd1);
        end

        // Backpressure: outputs freeze, then drain and load together.
        m_arready = 1'b0;
        held_id   = m_arid;
        held_addr = m_araddr;
        for (int k = 0; k < 5; k++) begin
            rand_payload();
            cycle();
            chk("bp_id_stable", 64'(m_arid), 64'(held_id));
            chk("bp_addr_stable", 64'(m_araddr), 64'(held_addr));
        end
        m_arready = 1'b1;
        #1;
        chk("bp_release_grant", 64'(s_arready != 0), 64'd1);
        cycle();
        chk("bp_release_valid", 64'(m_arvalid), 64'd1);

        // Wrap and skip: pointer at 3, only master 1 requesting.
        do_reset();
        s_arvalid = 4'b0100;
        cycle();
        s_arvalid = 4'b0010;
        #1;
        chk("wrap_grant_m1", 64'(s_arready), 64'b0010);
        cycle();
        s_arvalid = 4'b0111;
        #1;
        chk("wrap_next_m2", 64'(s_arready), 64'b0100);
        cycle();

        // Enable low: pending output drains, no new grant.
        enable    = 1'b0;
        s_arvalid = 4'b0100;
        #1;
        chk("en_low_no_grant", 64'(s_arready), 64'd0);
        cycle();
        chk("en_low_drained", 64'(m_arvalid), 64'd0);
        enable = 1'b1;
        #1;
        chk("en_high_grant", 64'(s_arready), 64'b0100);
        cycle();

        // Mid-operation reset discards the in-flight request.
        s_arvalid = 4'b1111;
        m_arready = 1'b0;
        cycle();
        chk("mid_pending", 64'(m_arvalid), 64'd1);
        do_reset();
        m_arready = 1'b1;
        s_arvalid = 4'b1010;
        #1;
        chk("post_rst_lowest", 64'(s_arready), 64'b0010);
        cycle();

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(99) < 2) do_reset();
            s_arvalid = N'($urandom);
            m_arready = ($urandom_range(99) < 70);
            enable    = ($urandom_range(99) < 85);
            rand_payload();
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
